// File: rtl/pipe_pwr_ctrl.sv
// PIPE power-state and receiver-detect sequencer between the LTSSM and the PHY pins.
// Optional handshake watchdog compiled in with `define PIPE_PWR_CTRL_TIMEOUT_EN.
module pipe_pwr_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       phy_pipe_pclk,
    input  logic       reset,
    input  logic       pwr_req_valid,
    input  logic [1:0] pwr_req_state,
    input  logic       rxdet_req_valid,
    output logic       req_ready,
    input  logic       tx_elecidle_req,
    output logic       pwr_done,
    output logic       rxdet_done,
    output logic       rxdet_present,
    output logic       timeout_err,
    output logic [1:0] cur_state,
    output logic [1:0] phy_power_down,
    output logic       phy_tx_detrx_lpbk,
    output logic       phy_tx_elecidle,
    input  logic       phy_phy_status,
    input  logic [2:0] phy_rx_status
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P2 = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("pipe_pwr_ctrl: TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {INIT, IDLE, PWR_WAIT, RXDET_WAIT} state_t;

    state_t     state_q;
    logic       req_ready_q, pwr_done_q, rxdet_done_q, rxdet_present_q;
    logic [1:0] cur_state_q, target_q, power_down_q;
    logic       detrx_q, elecidle_q;

`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        timeout_err_q;
    logic [15:0] cnt_q;
`endif

    // Electrical idle while parked in IDLE: only P0 lets the LTSSM drive it.
    function automatic logic idle_eidle(input logic [1:0] st, input logic req);
        return (st == P0) ? req : 1'b1;
    endfunction

    always_ff @(posedge phy_pipe_pclk) begin
        if (reset) begin
            state_q         <= INIT;
            req_ready_q     <= 1'b0;
            pwr_done_q      <= 1'b0;
            rxdet_done_q    <= 1'b0;
            rxdet_present_q <= 1'b0;
            cur_state_q     <= P2;
            target_q        <= P2;
            power_down_q    <= P2;
            detrx_q         <= 1'b0;
            elecidle_q      <= 1'b1;
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
            timeout_err_q   <= 1'b0;
            cnt_q           <= '0;
`endif
        end else begin
            pwr_done_q      <= 1'b0;
            rxdet_done_q    <= 1'b0;
            rxdet_present_q <= 1'b0;
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
            timeout_err_q   <= 1'b0;
`endif
            case (state_q)
                INIT: begin
                    if (!phy_phy_status) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    elecidle_q <= idle_eidle(cur_state_q, tx_elecidle_req);
                    // Power requests win; a concurrent rxdet request stays pending.
                    if (pwr_req_valid) begin
                        if (pwr_req_state != cur_state_q) begin
                            state_q      <= PWR_WAIT;
                            req_ready_q  <= 1'b0;
                            target_q     <= pwr_req_state;
                            power_down_q <= pwr_req_state;
                            elecidle_q   <= 1'b1;
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
                            cnt_q        <= '0;
`endif
                        end else begin
                            pwr_done_q <= 1'b1;
                        end
                    end else if (rxdet_req_valid) begin
                        if (cur_state_q[1]) begin
                            state_q     <= RXDET_WAIT;
                            req_ready_q <= 1'b0;
                            detrx_q     <= 1'b1;
                            elecidle_q  <= 1'b1;
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end else begin
                            rxdet_done_q <= 1'b1;
                        end
                    end
                end
                PWR_WAIT: begin
                    if (phy_phy_status) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        cur_state_q <= target_q;
                        pwr_done_q  <= 1'b1;
                        elecidle_q  <= idle_eidle(target_q, tx_elecidle_req);
                    end
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_q       <= IDLE;
                        req_ready_q   <= 1'b1;
                        power_down_q  <= cur_state_q;
                        timeout_err_q <= 1'b1;
                        elecidle_q    <= idle_eidle(cur_state_q, tx_elecidle_req);
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                RXDET_WAIT: begin
                    if (phy_phy_status) begin
                        state_q         <= IDLE;
                        req_ready_q     <= 1'b1;
                        rxdet_done_q    <= 1'b1;
                        rxdet_present_q <= (phy_rx_status == 3'b011);
                        detrx_q         <= 1'b0;
                        elecidle_q      <= idle_eidle(cur_state_q, tx_elecidle_req);
                    end
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_q       <= IDLE;
                        req_ready_q   <= 1'b1;
                        detrx_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        elecidle_q    <= idle_eidle(cur_state_q, tx_elecidle_req);
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign pwr_done          = pwr_done_q;
    assign rxdet_done        = rxdet_done_q;
    assign rxdet_present     = rxdet_present_q;
    assign cur_state         = cur_state_q;
    assign phy_power_down    = power_down_q;
    assign phy_tx_detrx_lpbk = detrx_q;
    assign phy_tx_elecidle   = elecidle_q;
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
    assign timeout_err       = timeout_err_q;
`else
    assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_pwr_ctrl.sv
// Scoreboard bench for pipe_pwr_ctrl: expected completions queued at request time,
// popped when a done/timeout pulse appears. Inputs driven and outputs sampled on negedge.
module tb_pipe_pwr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwr_req_valid = 1'b0;
    logic [1:0] pwr_req_state = 2'd0;
    logic       rxdet_req_valid = 1'b0;
    logic       tx_elecidle_req = 1'b0;
    logic       phy_phy_status = 1'b1;
    logic [2:0] phy_rx_status = 3'd0;
    logic       req_ready, pwr_done, rxdet_done, rxdet_present, timeout_err;
    logic [1:0] cur_state, phy_power_down;
    logic       phy_tx_detrx_lpbk, phy_tx_elecidle;

    always #5 clk = ~clk;

    pipe_pwr_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .phy_pipe_pclk    (clk),
        .reset            (reset),
        .pwr_req_valid    (pwr_req_valid),
        .pwr_req_state    (pwr_req_state),
        .rxdet_req_valid  (rxdet_req_valid),
        .req_ready        (req_ready),
        .tx_elecidle_req  (tx_elecidle_req),
        .pwr_done         (pwr_done),
        .rxdet_done       (rxdet_done),
        .rxdet_present    (rxdet_present),
        .timeout_err      (timeout_err),
        .cur_state        (cur_state),
        .phy_power_down   (phy_power_down),
        .phy_tx_detrx_lpbk(phy_tx_detrx_lpbk),
        .phy_tx_elecidle  (phy_tx_elecidle),
        .phy_phy_status   (phy_phy_status),
        .phy_rx_status    (phy_rx_status)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic       present;
        logic [1:0] cur;
    } exp_t;

    localparam logic [1:0] K_PWR = 2'd0, K_RXDET = 2'd1, K_TO = 2'd2;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Completion monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t obs, e;
        if (pwr_done || rxdet_done || timeout_err) begin
            obs.kind    = timeout_err ? K_TO : (rxdet_done ? K_RXDET : K_PWR);
            obs.present = rxdet_present;
            obs.cur     = cur_state;
            n_cmp++;
            if ((int'(pwr_done) + int'(rxdet_done) + int'(timeout_err)) != 1) begin
                n_err++;
                $display("FAIL sb_multi_pulse: got pwr/rxdet/to=%b%b%b expected one-hot",
                         pwr_done, rxdet_done, timeout_err);
            end else if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got pulse kind=%0d cur=%0d expected none", obs.kind, obs.cur);
            end else begin
                e = sb_q.pop_front();
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got kind=%0d present=%0d cur=%0d expected kind=%0d present=%0d cur=%0d",
                             obs.kind, obs.present, obs.cur, e.kind, e.present, e.cur);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        phy_phy_status = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({req_ready, phy_power_down, phy_tx_elecidle, cur_state, phy_tx_detrx_lpbk,
                 pwr_done, rxdet_done, rxdet_present, timeout_err} !== {1'b0, 2'd2, 1'b1, 2'd2, 5'b0}) begin
                n_err++;
                $display("FAIL reset_init[%0d]: got rdy=%b pd=%0d ei=%b cur=%0d det=%b expected rdy=0 pd=2 ei=1 cur=2 det=0",
                         i, req_ready, phy_power_down, phy_tx_elecidle, cur_state, phy_tx_detrx_lpbk);
            end
        end
        phy_phy_status = 1'b0;
        tick();
        n_cmp++;
        if ({req_ready, phy_power_down, phy_tx_elecidle} !== {1'b1, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL reset_ready: got rdy=%b pd=%0d ei=%b expected rdy=1 pd=2 ei=1",
                     req_ready, phy_power_down, phy_tx_elecidle);
        end
    endtask

    task automatic test_same_state();
        sb_q.push_back('{K_PWR, 1'b0, 2'd2});
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd2;
        tick();
        pwr_req_valid = 1'b0;
        n_cmp++;
        if ({req_ready, phy_power_down, phy_tx_detrx_lpbk} !== {1'b1, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL same_state: got rdy=%b pd=%0d det=%b expected rdy=1 pd=2 det=0",
                     req_ready, phy_power_down, phy_tx_detrx_lpbk);
        end
        tick();
    endtask

    task automatic test_rxdet_p2();
        logic [2:0] pats[3];
        logic       pres[3];
        pats = '{3'b011, 3'b000, 3'b111};
        pres = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{K_RXDET, pres[i], 2'd2});
            rxdet_req_valid = 1'b1;
            tick();
            rxdet_req_valid = 1'b0;
            n_cmp++;
            if ({phy_tx_detrx_lpbk, req_ready, phy_tx_elecidle} !== 3'b101) begin
                n_err++;
                $display("FAIL rxdet_start[%0d]: got det=%b rdy=%b ei=%b expected det=1 rdy=0 ei=1",
                         i, phy_tx_detrx_lpbk, req_ready, phy_tx_elecidle);
            end
            repeat (3) begin
                tick();
                n_cmp++;
                if ({phy_tx_detrx_lpbk, req_ready} !== 2'b10) begin
                    n_err++;
                    $display("FAIL rxdet_wait[%0d]: got det=%b rdy=%b expected det=1 rdy=0",
                             i, phy_tx_detrx_lpbk, req_ready);
                end
            end
            phy_rx_status = pats[i];
            phy_phy_status = 1'b1;
            tick();
            phy_phy_status = 1'b0;
            phy_rx_status = 3'd0;
            n_cmp++;
            if ({phy_tx_detrx_lpbk, req_ready, cur_state} !== {1'b0, 1'b1, 2'd2}) begin
                n_err++;
                $display("FAIL rxdet_end[%0d]: got det=%b rdy=%b cur=%0d expected det=0 rdy=1 cur=2",
                         i, phy_tx_detrx_lpbk, req_ready, cur_state);
            end
        end
    endtask

    task automatic test_pwr_p2_to_p0();
        tx_elecidle_req = 1'b0;
        sb_q.push_back('{K_PWR, 1'b0, 2'd0});
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd0;
        tick();
        pwr_req_valid = 1'b0;
        n_cmp++;
        if ({phy_power_down, req_ready, phy_tx_elecidle, cur_state} !== {2'd0, 1'b0, 1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL p0_accept: got pd=%0d rdy=%b ei=%b cur=%0d expected pd=0 rdy=0 ei=1 cur=2",
                     phy_power_down, req_ready, phy_tx_elecidle, cur_state);
        end
        repeat (4) begin
            tick();
            n_cmp++;
            if ({req_ready, phy_tx_elecidle} !== 2'b01) begin
                n_err++;
                $display("FAIL p0_wait: got rdy=%b ei=%b expected rdy=0 ei=1", req_ready, phy_tx_elecidle);
            end
        end
        phy_phy_status = 1'b1;
        tick();
        phy_phy_status = 1'b0;
        n_cmp++;
        if ({cur_state, req_ready, phy_tx_elecidle} !== {2'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL p0_done: got cur=%0d rdy=%b ei=%b expected cur=0 rdy=1 ei=0",
                     cur_state, req_ready, phy_tx_elecidle);
        end
        tx_elecidle_req = 1'b1;
        tick();
        n_cmp++;
        if (phy_tx_elecidle !== 1'b1) begin
            n_err++;
            $display("FAIL p0_eidle_hi: got %b expected 1", phy_tx_elecidle);
        end
        tx_elecidle_req = 1'b0;
        tick();
        n_cmp++;
        if (phy_tx_elecidle !== 1'b0) begin
            n_err++;
            $display("FAIL p0_eidle_lo: got %b expected 0", phy_tx_elecidle);
        end
    endtask

    task automatic test_idle_status_ignored();
        phy_phy_status = 1'b1;
        repeat (3) begin
            tick();
            n_cmp++;
            if ({req_ready, cur_state, phy_power_down} !== {1'b1, 2'd0, 2'd0}) begin
                n_err++;
                $display("FAIL idle_status: got rdy=%b cur=%0d pd=%0d expected rdy=1 cur=0 pd=0",
                         req_ready, cur_state, phy_power_down);
            end
        end
        phy_phy_status = 1'b0;
        tick();
    endtask

    task automatic test_rxdet_reject();
        sb_q.push_back('{K_RXDET, 1'b0, 2'd0});
        phy_rx_status = 3'b011;
        rxdet_req_valid = 1'b1;
        tick();
        rxdet_req_valid = 1'b0;
        repeat (4) begin
            n_cmp++;
            if ({phy_tx_detrx_lpbk, req_ready, phy_power_down} !== {1'b0, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL rxdet_reject: got det=%b rdy=%b pd=%0d expected det=0 rdy=1 pd=0",
                         phy_tx_detrx_lpbk, req_ready, phy_power_down);
            end
            tick();
        end
        phy_rx_status = 3'd0;
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{K_PWR, 1'b0, 2'd3});
        sb_q.push_back('{K_RXDET, 1'b1, 2'd3});
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd3;
        rxdet_req_valid = 1'b1;
        tick();
        pwr_req_valid = 1'b0;
        n_cmp++;
        if ({phy_power_down, phy_tx_detrx_lpbk, req_ready} !== {2'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_pwr_first: got pd=%0d det=%b rdy=%b expected pd=3 det=0 rdy=0",
                     phy_power_down, phy_tx_detrx_lpbk, req_ready);
        end
        repeat (2) tick();
        phy_phy_status = 1'b1;
        tick();
        phy_phy_status = 1'b0;
        n_cmp++;
        if ({cur_state, req_ready, phy_tx_detrx_lpbk} !== {2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_pwr_done: got cur=%0d rdy=%b det=%b expected cur=3 rdy=1 det=0",
                     cur_state, req_ready, phy_tx_detrx_lpbk);
        end
        tick();
        rxdet_req_valid = 1'b0;
        n_cmp++;
        if ({phy_tx_detrx_lpbk, req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_rxdet_start: got det=%b rdy=%b expected det=1 rdy=0",
                     phy_tx_detrx_lpbk, req_ready);
        end
        tick();
        phy_rx_status = 3'b011;
        phy_phy_status = 1'b1;
        tick();
        phy_phy_status = 1'b0;
        phy_rx_status = 3'd0;
        n_cmp++;
        if ({phy_tx_detrx_lpbk, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_rxdet_end: got det=%b rdy=%b expected det=0 rdy=1",
                     phy_tx_detrx_lpbk, req_ready);
        end
    endtask

    task automatic test_timeout();
        // Return to P0 first.
        sb_q.push_back('{K_PWR, 1'b0, 2'd0});
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd0;
        tick();
        pwr_req_valid = 1'b0;
        tick();
        phy_phy_status = 1'b1;
        tick();
        phy_phy_status = 1'b0;
        n_cmp++;
        if (cur_state !== 2'd0) begin
            n_err++;
            $display("FAIL to_setup: got cur=%0d expected 0", cur_state);
        end
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
        sb_q.push_back('{K_TO, 1'b0, 2'd0});
`else
        sb_q.push_back('{K_PWR, 1'b0, 2'd1});
`endif
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd1;
        tick();
        pwr_req_valid = 1'b0;
        n_cmp++;
        if ({phy_power_down, req_ready} !== {2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL to_accept: got pd=%0d rdy=%b expected pd=1 rdy=0", phy_power_down, req_ready);
        end
`ifdef PIPE_PWR_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (k < 16) begin
                if ({timeout_err, req_ready, phy_power_down} !== {1'b0, 1'b0, 2'd1}) begin
                    n_err++;
                    $display("FAIL to_wait[%0d]: got to=%b rdy=%b pd=%0d expected to=0 rdy=0 pd=1",
                             k, timeout_err, req_ready, phy_power_down);
                end
            end else if ({timeout_err, req_ready, phy_power_down, cur_state} !== {1'b1, 1'b1, 2'd0, 2'd0}) begin
                n_err++;
                $display("FAIL to_fire: got to=%b rdy=%b pd=%0d cur=%0d expected to=1 rdy=1 pd=0 cur=0",
                         timeout_err, req_ready, phy_power_down, cur_state);
            end
        end
        tick();
        n_cmp++;
        if ({timeout_err, pwr_done} !== 2'b00) begin
            n_err++;
            $display("FAIL to_after: got to=%b done=%b expected 0 0", timeout_err, pwr_done);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_cmp++;
            if ({timeout_err, req_ready, pwr_done} !== 3'b000) begin
                n_err++;
                $display("FAIL noto_wait[%0d]: got to=%b rdy=%b done=%b expected 0 0 0",
                         k, timeout_err, req_ready, pwr_done);
            end
        end
        phy_phy_status = 1'b1;
        tick();
        phy_phy_status = 1'b0;
        n_cmp++;
        if ({cur_state, req_ready} !== {2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL noto_done: got cur=%0d rdy=%b expected cur=1 rdy=1", cur_state, req_ready);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_wait();
        pwr_req_valid = 1'b1;
        pwr_req_state = 2'd3;
        tick();
        pwr_req_valid = 1'b0;
        n_cmp++;
        if ({phy_power_down, req_ready} !== {2'd3, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_accept: got pd=%0d rdy=%b expected pd=3 rdy=0", phy_power_down, req_ready);
        end
        tick();
        reset = 1'b1;
        phy_phy_status = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({req_ready, phy_power_down, phy_tx_elecidle, cur_state, phy_tx_detrx_lpbk,
             pwr_done, rxdet_done, rxdet_present, timeout_err} !== {1'b0, 2'd2, 1'b1, 2'd2, 5'b0}) begin
            n_err++;
            $display("FAIL rst_mid_values: got rdy=%b pd=%0d ei=%b cur=%0d det=%b done=%b expected rdy=0 pd=2 ei=1 cur=2 det=0 done=0",
                     req_ready, phy_power_down, phy_tx_elecidle, cur_state, phy_tx_detrx_lpbk, pwr_done);
        end
        repeat (3) begin
            tick();
            n_cmp++;
            if ({req_ready, pwr_done} !== 2'b00) begin
                n_err++;
                $display("FAIL rst_mid_init: got rdy=%b done=%b expected rdy=0 done=0", req_ready, pwr_done);
            end
        end
        phy_phy_status = 1'b0;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got %b expected 1", req_ready);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_same_state();
        test_rxdet_p2();
        test_pwr_p2_to_p0();
        test_idle_status_ignored();
        test_rxdet_reject();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_pwr_ctrl.md
# pipe_pwr_ctrl

Power-state and receiver-detection sequencer for the USB 3.1 PIPE PHY interface. It takes power-state change and receiver-detect requests from the link layer (LTSSM) and drives `phy_power_down`, `phy_tx_detrx_lpbk` and `phy_tx_elecidle`. It completes each operation on the PHY's `phy_phy_status` handshake and reports results back to the LTSSM. It sits between the LTSSM and the PIPE pins that the PHY agent drives and monitors.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for `phy_phy_status` before abort. Legal range 2 to 65535.

Ports:
- `phy_pipe_pclk` in 1: PIPE clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `pwr_req_valid` in 1: power-state change request.
- `pwr_req_state` in 2: target state (0=P0, 1=P1, 2=P2, 3=P3).
- `rxdet_req_valid` in 1: receiver-detect request.
- `req_ready` out 1: controller idle; a request is accepted on `valid && req_ready`.
- `tx_elecidle_req` in 1: LTSSM electrical-idle request; honoured only in P0.
- `pwr_done` out 1: one-cycle pulse when a power change completes.
- `rxdet_done` out 1: one-cycle pulse when receiver detection completes.
- `rxdet_present` out 1: result, valid while `rxdet_done` is high.
- `timeout_err` out 1: one-cycle pulse on handshake timeout.
- `cur_state` out 2: current committed power state.
- `phy_power_down` out 2: PIPE PowerDown.
- `phy_tx_detrx_lpbk` out 1: PIPE TxDetectRx/Loopback.
- `phy_tx_elecidle` out 1: PIPE TxElecIdle.
- `phy_phy_status` in 1: PIPE PhyStatus.
- `phy_rx_status` in 3: PIPE RxStatus.

## Operation
FSM states: `INIT`, `IDLE`, `PWR_WAIT`, `RXDET_WAIT`.
- Reset values:
  - `phy_power_down` = 2'b10 (P2), `cur_state` = 2.
  - `phy_tx_elecidle` = 1.
  - All other outputs 0.
  - FSM enters `INIT`.
- `INIT`: the PHY holds `phy_phy_status` high after reset. The FSM waits for the first sampled `phy_phy_status == 0`, then moves to `IDLE`. `req_ready` = 0.
- `IDLE`: `req_ready` = 1.
  - If `pwr_req_valid` and `rxdet_req_valid` are high together, the power request wins and the receiver-detect request stays pending.
  - Power request, target differs from `cur_state`: `phy_power_down` <= target, go to `PWR_WAIT`.
  - Power request, target equals `cur_state`: no PIPE activity; `pwr_done` pulses the next cycle; stay in `IDLE`.
  - `rxdet_req_valid` with `cur_state` P2 or P3: `phy_tx_detrx_lpbk` <= 1, go to `RXDET_WAIT`.
  - `rxdet_req_valid` with `cur_state` P0 or P1: rejected. `rxdet_done` = 1 and `rxdet_present` = 0 the next cycle; no PIPE activity.
- `PWR_WAIT`: on sampled `phy_phy_status == 1`, `cur_state` <= target, `pwr_done` pulses, return to `IDLE`.
- `RXDET_WAIT`: on sampled `phy_phy_status == 1`:
  - `rxdet_present` = (`phy_rx_status == 3'b011`);
  - `rxdet_done` pulses;
  - `phy_tx_detrx_lpbk` <= 0;
  - return to `IDLE`.
- `phy_tx_elecidle`:
  - 1 whenever `cur_state != P0`, throughout `PWR_WAIT`, and throughout `RXDET_WAIT`;
  - in P0 and `IDLE`, equals `tx_elecidle_req`, registered.
- `phy_phy_status` seen in `IDLE` is ignored. No spurious done pulse.
- `reset` asserted in any state: all outputs return to reset values the next edge, FSM goes to `INIT`, and the pending operation is dropped without a done pulse.

## Timing
- Request accept at edge N: PIPE outputs change at edge N+1 and `req_ready` is 0 from N+1.
- PhyStatus sampled high at edge M: done pulse, `cur_state` update and `req_ready` = 1 all occur at M+1. The next request may be accepted at M+1.
- Minimum handshake latency is 2 cycles from accept to done.
- All outputs are registered. No combinational input-to-output paths.
- The timeout counter is 16 bits and saturates. It clears on entry to each WAIT state.

## Configuration
- `PIPE_PWR_CTRL_TIMEOUT_EN` defined (watchdog compiled in):
  - the counter runs in `PWR_WAIT` and `RXDET_WAIT`;
  - reaching `TIMEOUT_CYCLES` pulses `timeout_err`;
  - `phy_power_down` reverts to the old `cur_state` and `phy_tx_detrx_lpbk` returns to 0;
  - no done pulse; FSM goes to `IDLE`.
- Not defined: no counter logic. WAIT states wait indefinitely and `timeout_err` is tied to 0.

## Test plan
- Reset, PHY holds `phy_phy_status` = 1 for 10 cycles, then 0 -> `req_ready` rises 1 cycle after the low is sampled; `phy_power_down` = 2, `phy_tx_elecidle` = 1.
- P2 -> P0 request, PHY pulses PhyStatus 5 cycles later -> `phy_power_down` = 0 one cycle after accept; `pwr_done` one cycle after the pulse; `cur_state` = 0; `phy_tx_elecidle` then follows `tx_elecidle_req`.
- Receiver detect in P2, PHY returns RxStatus 3'b011 with PhyStatus -> `phy_tx_detrx_lpbk` high during the wait, `rxdet_done` = 1 with `rxdet_present` = 1. Repeat with 3'b000 -> `rxdet_present` = 0.
- Receiver detect in P0 -> rejected: `rxdet_done` = 1, `rxdet_present` = 0, `phy_tx_detrx_lpbk` never asserted. Simultaneous pwr(P3) and rxdet requests -> power request served first.
- With `TIMEOUT_CYCLES` = 16 and the macro defined, P0 -> P1 with no PhyStatus -> `timeout_err` on cycle 16 of the wait, `phy_power_down` back to 0, no `pwr_done`.
- `reset` asserted mid-`PWR_WAIT` -> next edge all outputs at reset values, FSM in `INIT`, no done pulse.
